// File: rtl/cme_pkg.sv
// cme_pkg: shared types and default sizes for the count-match event block.
//   cme_state_t : FSM states IDLE / ARMED / DRAIN
//   CME_*_W     : default widths for count, pending counter and sequence number
//   PEND_MAX    : saturation level of the pending-event counter at default width
package cme_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } cme_state_t;

  localparam int unsigned CME_CNT_W  = 4;
  localparam int unsigned CME_PEND_W = 3;
  localparam int unsigned CME_SEQ_W  = 8;

  function automatic int unsigned pend_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  localparam int unsigned PEND_MAX = pend_max(CME_PEND_W);

endpackage

// File: rtl/cme_pend_ctr.sv
// cme_pend_ctr: saturating up/down counter of queued events.
//   clk, rst  : clock, asynchronous active-high reset
//   inc, dec  : request +1 / -1 (both together leave the count unchanged)
//   count     : current number of queued events
//   full      : count at its maximum
//   empty     : count is zero
//   ovf_pulse : an increment was dropped because the counter was full
module cme_pend_ctr
  import cme_pkg::*;
#(
  parameter int unsigned W = CME_PEND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         ovf_pulse
);

  logic [W-1:0] r_count;

  assign count     = r_count;
  assign full      = &r_count;
  assign empty     = (r_count == '0);
  assign ovf_pulse = inc & ~dec & full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !dec && !full) begin
      r_count <= r_count + W'(1);
    end else if (dec && !inc && !empty) begin
      r_count <= r_count - W'(1);
    end
  end

endmodule

// File: rtl/cnt_match_event.sv
// cnt_match_event: watches an upstream free-running count, raises an event each
// time it newly equals a latched match value, queues events in a saturating
// pending count and delivers them one at a time over valid/ready with a
// sequence number.
//   clk, rst            : clock, asynchronous active-high reset
//   cnt_in              : upstream count
//   match_val           : compare value, latched on an accepted arm
//   arm / disarm        : start watching (IDLE only) / stop watching (ARMED only)
//   evt_valid/evt_ready : event handshake, evt_seq numbers the presented event
//   pending             : queued event count
//   ovf                 : sticky, a hit was dropped at saturation (cleared on arm)
//   busy                : FSM not in IDLE
//   wrap_cnt            : upstream wrap counter, present only with CME_WRAP_DETECT_EN
module cnt_match_event
  import cme_pkg::*;
#(
  parameter int unsigned CNT_W  = CME_CNT_W,
  parameter int unsigned PEND_W = CME_PEND_W,
  parameter int unsigned SEQ_W  = CME_SEQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic [CNT_W-1:0]  match_val,
  input  logic              arm,
  input  logic              disarm,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [SEQ_W-1:0]  evt_seq,
  output logic [PEND_W-1:0] pending,
  output logic              ovf,
  output logic              busy
`ifdef CME_WRAP_DETECT_EN
  ,
  output logic [SEQ_W-1:0]  wrap_cnt
`endif
);

  cme_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt_q;
  logic [CNT_W-1:0]  r_match_q;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_ovf;

  logic              w_hit;
  logic              w_pop;
  logic              w_arm_acc;
  logic              w_empty;
  logic              w_full_unused;
  logic              w_ovf_pulse;

  // A hit needs a change of count so a stalled upstream does not re-fire.
  assign w_hit     = (r_state == ARMED) && (cnt_in == r_match_q) && (cnt_in != r_cnt_q);
  assign w_pop     = evt_valid & evt_ready;
  assign w_arm_acc = (r_state == IDLE) & arm;

  cme_pend_ctr #(.W(PEND_W)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .inc       (w_hit),
    .dec       (w_pop),
    .count     (pending),
    .full      (w_full_unused),
    .empty     (w_empty),
    .ovf_pulse (w_ovf_pulse)
  );

  assign evt_valid = ~w_empty;
  assign evt_seq   = r_seq;
  assign ovf       = r_ovf;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt_q   <= '0;
      r_match_q <= '0;
      r_seq     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_cnt_q <= cnt_in;
      if (w_pop) r_seq <= r_seq + SEQ_W'(1);
      if (w_ovf_pulse) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state   <= ARMED;
            r_match_q <= match_val;
            r_ovf     <= 1'b0;
          end
        end
        ARMED: begin
          if (disarm) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_empty) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CME_WRAP_DETECT_EN
  logic [SEQ_W-1:0] r_wrap_cnt;

  assign wrap_cnt = r_wrap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_cnt <= '0;
    end else if (w_arm_acc) begin
      r_wrap_cnt <= '0;
    end else if (cnt_in < r_cnt_q) begin
      r_wrap_cnt <= r_wrap_cnt + SEQ_W'(1);
    end
  end
`else
  logic w_arm_acc_unused;
  assign w_arm_acc_unused = w_arm_acc;
`endif

endmodule

// File: tb/tb_cnt_match_event.sv
module tb_cnt_match_event;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic [3:0] match_val;
  logic       arm;
  logic       disarm;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_seq;
  logic [2:0] pending;
  logic       ovf;
  logic       busy;
`ifdef CME_WRAP_DETECT_EN
  logic [7:0] wrap_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;
  int exp_q[$];

  cnt_match_event #(.CNT_W(4), .PEND_W(3), .SEQ_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .match_val (match_val),
    .arm       (arm),
    .disarm    (disarm),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_seq   (evt_seq),
    .pending   (pending),
    .ovf       (ovf),
    .busy      (busy)
`ifdef CME_WRAP_DETECT_EN
    ,
    .wrap_cnt  (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted event must carry the next queued sequence number.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got seq %0d expected no event", evt_seq);
      end else begin
        chk("sb_seq", int'(evt_seq), exp_q.pop_front());
      end
    end
  end

  // One clock cycle; inputs set before the call apply to this cycle.
  task automatic cyc();
    @(negedge clk);
    if (evt_valid) vcount++;
    @(posedge clk);
    #1;
  endtask

  task automatic period();
    for (int i = 0; i < 16; i++) begin
      cnt_in = 4'(i);
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cnt_in = '0; match_val = '0; arm = 0; disarm = 0; evt_ready = 0;
    @(posedge clk); #1;
    chk("rst_pending", pending, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq", evt_seq, 0);
    rst = 1'b0;

    // Single match with sink always ready
    evt_ready = 1; match_val = 4'd5; arm = 1;
    cyc();
    arm = 0;
    chk("arm_busy", busy, 1);
    exp_q.push_back(0);
    vcount = 0;
    period();
    chk("single_valid_cycles", vcount, 1);
    chk("single_seq", evt_seq, 1);
    chk("single_pending", pending, 0);

    // Disarm with nothing pending: one DRAIN cycle then IDLE
    disarm = 1; cyc(); disarm = 0;
    chk("drain0_busy", busy, 1);
    cyc();
    chk("drain0_idle", busy, 0);

    // Fill to saturation with sink stalled
    evt_ready = 0; match_val = 4'd2; arm = 1;
    cyc();
    arm = 0;
    for (int p = 0; p < 7; p++) period();
    chk("fill_pending", pending, 7);
    chk("fill_ovf", ovf, 0);
    chk("fill_valid", evt_valid, 1);
    chk("stall_seq", evt_seq, 1);

    // Hit and pop in the same cycle at saturation
    exp_q.push_back(1);
    for (int i = 0; i < 16; i++) begin
      cnt_in = 4'(i);
      evt_ready = (i == 2);
      cyc();
    end
    evt_ready = 0;
    chk("hitpop_pending", pending, 7);
    chk("hitpop_ovf", ovf, 0);
    chk("hitpop_seq", evt_seq, 2);

    // Eighth stalled hit is dropped
    period();
    chk("sat_pending", pending, 7);
    chk("sat_ovf", ovf, 1);

    // Drain the queue, count held so no new hits
    for (int s = 2; s <= 8; s++) exp_q.push_back(s);
    evt_ready = 1;
    for (int i = 0; i < 10; i++) cyc();
    chk("drain7_pending", pending, 0);
    chk("drain7_seq", evt_seq, 9);
    chk("ovf_sticky", ovf, 1);

    // Disarm with two pending; arm in DRAIN ignored, no hits in DRAIN
    evt_ready = 0;
    period(); period();
    chk("pre_disarm_pending", pending, 2);
    disarm = 1; cyc(); disarm = 0;
    arm = 1;
    period();
    arm = 0;
    chk("drain_no_hits", pending, 2);
    chk("drain_busy", busy, 1);
    chk("drain_arm_ignored_ovf", ovf, 1);
    exp_q.push_back(9); exp_q.push_back(10);
    evt_ready = 1;
    cyc(); cyc();
    chk("drain2_busy_still", busy, 1);
    cyc(); cyc();
    chk("drain2_idle", busy, 0);
    chk("drain2_seq", evt_seq, 11);

    // Asynchronous reset with three pending
    evt_ready = 0; match_val = 4'd2; arm = 1;
    cyc();
    arm = 0;
    chk("rearm_ovf_clear", ovf, 0);
    period(); period(); period();
    chk("pre_rst_pending", pending, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pending", pending, 0);
    chk("async_rst_valid", evt_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_seq", evt_seq, 0);
    cnt_in = '0;
    cyc();
    chk("rst_hold_pending", pending, 0);
    chk("rst_hold_ovf", ovf, 0);
    rst = 1'b0;

`ifdef CME_WRAP_DETECT_EN
    for (int p = 0; p < 3; p++) period();
    cnt_in = '0;
    cyc();
    chk("wrap_cnt_3", wrap_cnt, 3);
    arm = 1; cyc(); arm = 0;
    chk("wrap_cnt_cleared", wrap_cnt, 0);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
